// File: rtl/filter_pkg.sv
// Shared types and widths for the single-pixel filter frame controllers.
package filter_pkg;

  localparam int COORD_W  = 12;
  localparam int PIXCNT_W = 24;
  localparam int CREDIT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/credit_counter.sv
// Downstream buffer credit tracker: take a credit per issue, return one per pop,
// and flag a pop that would push the count past the buffer depth.
module credit_counter
  import filter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic dec,
  input  logic inc,
  output logic empty,
  output logic overflow
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(DEPTH);

  logic [CREDIT_W-1:0] count_reg;
  logic [CREDIT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    overflow   = 1'b0;
    if (inc && !dec) begin
      if (count_reg == FULL) begin
        overflow = 1'b1;
      end else begin
        count_next = count_reg + CREDIT_W'(1);
      end
    end else if (dec && !inc && count_reg != '0) begin
      count_next = count_reg - CREDIT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_reg <= FULL;
    end else begin
      count_reg <= count_next;
    end
  end

  assign empty = (count_reg == '0);

endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for per-pixel filters: raster coordinate generation, credit-gated
// issue strobe, WREN return counting and frame-done reporting.
module filter_frame_ctrl
  import filter_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int CREDITS = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  input  logic               IN_VALID,
  input  logic               DS_POP,
  output logic [COORD_W-1:0] POSX,
  output logic [COORD_W-1:0] POSY,
  output logic               READY,
  input  logic               WREN
);

  localparam logic [COORD_W-1:0]  X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0]  Y_LAST = COORD_W'(HEIGHT - 1);
  localparam logic [PIXCNT_W-1:0] TOTAL  = PIXCNT_W'(WIDTH * HEIGHT);

  state_t               state_reg, state_next;
  logic [COORD_W-1:0]   posx_reg, posx_next;
  logic [COORD_W-1:0]   posy_reg, posy_next;
  logic [PIXCNT_W-1:0]  issued_reg, issued_next;
  logic [PIXCNT_W-1:0]  received_reg, received_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;
  logic                 credit_empty;
  logic                 credit_overflow;
  logic                 ready;

  assign ready = (state_reg == RUN) && IN_VALID && !credit_empty;

  credit_counter #(
    .DEPTH(CREDITS)
  ) u_credit (
    .CLK     (CLK),
    .RST     (RST),
    .dec     (ready),
    .inc     (DS_POP),
    .empty   (credit_empty),
    .overflow(credit_overflow)
  );

  always_comb begin
    state_next    = state_reg;
    posx_next     = posx_reg;
    posy_next     = posy_reg;
    issued_next   = issued_reg;
    received_next = received_reg;
    done_next     = 1'b0;
    err_next      = err_reg;

    case (state_reg)
      IDLE: begin
        if (START) begin
          state_next    = RUN;
          posx_next     = '0;
          posy_next     = '0;
          issued_next   = '0;
          received_next = '0;
          err_next      = 1'b0;
        end
      end
      RUN: begin
        if (ready) begin
          issued_next = issued_reg + PIXCNT_W'(1);
          if (posx_reg == X_LAST) begin
            posx_next = '0;
            posy_next = posy_reg + COORD_W'(1);
            if (posy_reg == Y_LAST) begin
              state_next = DRAIN;
            end
          end else begin
            posx_next = posx_reg + COORD_W'(1);
          end
        end
      end
      default: begin
      end
    endcase

    // Returns are only legal inside a frame and never ahead of what was issued.
    if (WREN) begin
      if (state_reg == IDLE || received_reg >= issued_reg) begin
        err_next = 1'b1;
      end else begin
        received_next = received_reg + PIXCNT_W'(1);
      end
    end

    // Finish on the cycle the last return lands so DONE is registered one cycle later.
    if (state_reg == DRAIN && received_next == TOTAL) begin
      done_next  = 1'b1;
      state_next = IDLE;
    end

    if (credit_overflow) begin
      err_next = 1'b1;
    end

    busy_next = (state_next != IDLE) || done_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      posx_reg     <= '0;
      posy_reg     <= '0;
      issued_reg   <= '0;
      received_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      posx_reg     <= posx_next;
      posy_reg     <= posy_next;
      issued_reg   <= issued_next;
      received_reg <= received_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign POSX  = posx_reg;
  assign POSY  = posy_reg;
  assign BUSY  = busy_reg;
  assign DONE  = done_reg;
  assign ERR   = err_reg;
  assign READY = ready;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Directed bench: three controller instances (4x2/8 credits, 4x2/2 credits, 1x1/8 credits)
// each driven by a two-cycle filter model.
module tb_filter_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A: 4x2, 8 credits, DS_POP echoes WREN
  logic a_start = 0, a_in_valid = 0, a_busy, a_done, a_err, a_ready, a_wren;
  logic [11:0] a_posx, a_posy;
  logic [1:0] a_pipe;
  assign a_wren = a_pipe[1];

  // Instance B: 4x2, 2 credits, DS_POP driven by hand
  logic b_start = 0, b_in_valid = 0, b_pop = 0, b_busy, b_done, b_err, b_ready, b_wren;
  logic [11:0] b_posx, b_posy;
  logic [1:0] b_pipe;
  assign b_wren = b_pipe[1];

  // Instance C: 1x1, 8 credits, extra WREN injection
  logic c_start = 0, c_in_valid = 0, c_wren_inj = 0, c_busy, c_done, c_err, c_ready, c_wren, c_pop;
  logic [11:0] c_posx, c_posy;
  logic [1:0] c_pipe;
  assign c_wren = c_pipe[1] | c_wren_inj;
  assign c_pop  = c_pipe[1];

  filter_frame_ctrl #(.WIDTH(4), .HEIGHT(2), .CREDITS(8)) u_a (
    .CLK(clk), .RST(rst), .START(a_start), .BUSY(a_busy), .DONE(a_done), .ERR(a_err),
    .IN_VALID(a_in_valid), .DS_POP(a_wren), .POSX(a_posx), .POSY(a_posy),
    .READY(a_ready), .WREN(a_wren));

  filter_frame_ctrl #(.WIDTH(4), .HEIGHT(2), .CREDITS(2)) u_b (
    .CLK(clk), .RST(rst), .START(b_start), .BUSY(b_busy), .DONE(b_done), .ERR(b_err),
    .IN_VALID(b_in_valid), .DS_POP(b_pop), .POSX(b_posx), .POSY(b_posy),
    .READY(b_ready), .WREN(b_wren));

  filter_frame_ctrl #(.WIDTH(1), .HEIGHT(1), .CREDITS(8)) u_c (
    .CLK(clk), .RST(rst), .START(c_start), .BUSY(c_busy), .DONE(c_done), .ERR(c_err),
    .IN_VALID(c_in_valid), .DS_POP(c_pop), .POSX(c_posx), .POSY(c_posy),
    .READY(c_ready), .WREN(c_wren));

  // Two-cycle filter latency; the filter is reset together with the controller.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_pipe <= 2'b00;
      b_pipe <= 2'b00;
      c_pipe <= 2'b00;
    end else begin
      a_pipe <= {a_pipe[0], a_ready};
      b_pipe <= {b_pipe[0], b_ready};
      c_pipe <= {c_pipe[0], c_ready};
    end
  end

  typedef struct {
    int cyc;
    int x;
    int y;
  } rec_t;

  rec_t a_log[$];
  rec_t b_log[$];
  rec_t c_log[$];
  int a_done_cyc = -1, b_done_cyc = -1, c_done_cyc = -1;
  int a_busy_cnt = 0;

  always @(negedge clk) begin
    rec_t r;
    if (a_ready) begin
      r.cyc = cyc; r.x = int'(a_posx); r.y = int'(a_posy);
      a_log.push_back(r);
    end
    if (b_ready) begin
      r.cyc = cyc; r.x = int'(b_posx); r.y = int'(b_posy);
      b_log.push_back(r);
    end
    if (c_ready) begin
      r.cyc = cyc; r.x = int'(c_posx); r.y = int'(c_posy);
      c_log.push_back(r);
    end
    if (a_done) a_done_cyc = cyc;
    if (b_done) b_done_cyc = cyc;
    if (c_done) c_done_cyc = cyc;
    if (a_busy) a_busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_in_valid = 1; b_in_valid = 1; c_in_valid = 1;
    rst = 1;
    #12;
    tests_run++;
    if ({a_posx, a_posy, a_busy, a_done, a_err, a_ready} !== 28'd0) begin
      tests_failed++;
      $display("FAIL reset_a: got posx=%0d posy=%0d busy=%b done=%b err=%b ready=%b required all 0",
               a_posx, a_posy, a_busy, a_done, a_err, a_ready);
    end
    tests_run++;
    if ({c_posx, c_posy, c_busy, c_done, c_err, c_ready} !== 28'd0) begin
      tests_failed++;
      $display("FAIL reset_c: got posx=%0d posy=%0d busy=%b done=%b err=%b ready=%b required all 0",
               c_posx, c_posy, c_busy, c_done, c_err, c_ready);
    end
    @(posedge clk); #1;
    rst = 0;
    tick();
    tests_run++;
    if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got ready=%b busy=%b required 0 0", a_ready, a_busy);
    end
    $display("[TB] reset checked at cycle %0d", cyc);
  endtask

  task automatic test_stream();
    int s;
    a_in_valid = 1;
    a_log.delete(); a_done_cyc = -1; a_busy_cnt = 0;
    a_start = 1; s = cyc;
    tick();
    a_start = 0;
    for (int i = 0; i < 40 && a_done_cyc < 0; i++) tick();
    tick(); tick();
    tests_run++;
    if (a_done_cyc < 0) begin
      tests_failed++;
      $display("FAIL stream_done: got no DONE within 40 cycles required DONE");
    end
    tests_run++;
    if (a_log.size() != 8) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d READY cycles required 8", a_log.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < a_log.size()) begin
        tests_run++;
        if (a_log[i].x != i % 4 || a_log[i].y != i / 4 || a_log[i].cyc != s + 1 + i) begin
          tests_failed++;
          $display("FAIL stream_pix%0d: got (%0d,%0d)@%0d required (%0d,%0d)@%0d", i,
                   a_log[i].x, a_log[i].y, a_log[i].cyc, i % 4, i / 4, s + 1 + i);
        end
      end
    end
    tests_run++;
    if (a_done_cyc != s + 11) begin
      tests_failed++;
      $display("FAIL stream_done_latency: got DONE at cycle %0d required %0d", a_done_cyc, s + 11);
    end
    tests_run++;
    if (a_busy_cnt != 11) begin
      tests_failed++;
      $display("FAIL stream_busy_span: got %0d BUSY cycles required 11", a_busy_cnt);
    end
    tests_run++;
    if (a_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_err: got ERR=%b required 0", a_err);
    end
    $display("[TB] stream frame started %0d done %0d", s, a_done_cyc);
  endtask

  task automatic test_in_valid();
    int s;
    logic exp_ready;
    int bad;
    a_log.delete(); a_done_cyc = -1;
    a_in_valid = 0;
    a_start = 1; s = cyc;
    tick();
    a_start = 0;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      a_in_valid = (k % 2 == 0);
      exp_ready = (k % 2 == 0);
      @(negedge clk);
      tests_run++;
      if (a_ready !== exp_ready) begin
        tests_failed++;
        $display("FAIL in_valid_ready_k%0d: got READY=%b required %b", k, a_ready, exp_ready);
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1;
    for (int i = 0; i < 20 && a_done_cyc < 0; i++) tick();
    tests_run++;
    if (a_log.size() != 8 || a_done_cyc < 0) begin
      tests_failed++;
      $display("FAIL in_valid_frame: got %0d pixels done_cyc=%0d required 8 pixels and DONE",
               a_log.size(), a_done_cyc);
    end
    for (int i = 0; i < a_log.size() && i < 8; i++) begin
      if (a_log[i].x != i % 4 || a_log[i].y != i / 4 || a_log[i].cyc != s + 1 + 2 * i) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL in_valid_coords: got %0d misplaced pixels required 0", bad);
    end
    $display("[TB] gated frame started %0d done %0d", s, a_done_cyc);
  endtask

  task automatic test_credit_limit();
    b_in_valid = 1; b_pop = 0;
    b_log.delete();
    b_start = 1;
    tick();
    b_start = 0;
    repeat (6) tick();
    tests_run++;
    if (b_log.size() != 2) begin
      tests_failed++;
      $display("FAIL credit_limit_count: got %0d READY required 2", b_log.size());
    end else begin
      tests_run++;
      if (b_log[0].x != 0 || b_log[0].y != 0 || b_log[1].x != 1 || b_log[1].y != 0) begin
        tests_failed++;
        $display("FAIL credit_limit_coords: got (%0d,%0d),(%0d,%0d) required (0,0),(1,0)",
                 b_log[0].x, b_log[0].y, b_log[1].x, b_log[1].y);
      end
    end
    tests_run++;
    if (b_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL credit_limit_stall: got READY=%b required 0", b_ready);
    end
    b_pop = 1;
    tick();
    b_pop = 0;
    repeat (3) tick();
    tests_run++;
    if (b_log.size() != 3 || b_log[b_log.size()-1].x != 2 || b_log[b_log.size()-1].y != 0) begin
      tests_failed++;
      $display("FAIL credit_one_pop: got %0d READY, last x=%0d required 3 with last (2,0)",
               b_log.size(), b_log.size() > 0 ? b_log[b_log.size()-1].x : -1);
    end
    $display("[TB] credit limit: %0d pixels issued with 2 credits", b_log.size());
  endtask

  task automatic test_credit_same_cycle();
    logic pop_pat [9];
    logic rdy_pat [9];
    int t_wait;
    pop_pat = '{1, 1, 0, 0, 1, 1, 1, 0, 0};
    rdy_pat = '{0, 1, 1, 0, 0, 1, 1, 1, 0};
    b_done_cyc = -1;
    for (int k = 0; k < 9; k++) begin
      b_pop = pop_pat[k];
      @(negedge clk);
      tests_run++;
      if (b_ready !== rdy_pat[k]) begin
        tests_failed++;
        $display("FAIL same_cycle_ready_k%0d: got READY=%b required %b", k, b_ready, rdy_pat[k]);
      end
      @(posedge clk); #1;
    end
    b_pop = 0;
    tests_run++;
    if (b_log.size() != 8 || b_log[3].x != 3 || b_log[3].y != 0 || b_log[4].x != 0 || b_log[4].y != 1) begin
      tests_failed++;
      $display("FAIL same_cycle_coords: got %0d pixels required 8 with (3,0),(0,1) at 3,4", b_log.size());
    end
    t_wait = 0;
    while (b_done_cyc < 0 && t_wait < 20) begin
      tick();
      t_wait++;
    end
    tests_run++;
    if (b_done_cyc < 0) begin
      tests_failed++;
      $display("FAIL credit_frame_done: got no DONE required DONE");
    end
    b_pop = 1;
    tick(); tick();
    b_pop = 0;
    tick();
    tests_run++;
    if (b_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL refill_err: got ERR=%b required 0", b_err);
    end
    b_pop = 1;
    tick();
    b_pop = 0;
    tick();
    tests_run++;
    if (b_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_err: got ERR=%b required 1", b_err);
    end
    b_log.delete();
    b_start = 1;
    tick();
    b_start = 0;
    tests_run++;
    if (b_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_clears_err: got ERR=%b required 0", b_err);
    end
    repeat (6) tick();
    tests_run++;
    if (b_log.size() != 2) begin
      tests_failed++;
      $display("FAIL overflow_credit_unchanged: got %0d READY required 2", b_log.size());
    end
    $display("[TB] credit overflow frame done %0d", b_done_cyc);
  endtask

  task automatic test_reset_midframe();
    int bad;
    a_in_valid = 1;
    a_start = 1;
    tick();
    a_start = 0;
    repeat (4) tick();
    #1;
    tests_run++;
    if (a_ready !== 1'b1 || a_posx !== 12'd0 || a_posy !== 12'd1) begin
      tests_failed++;
      $display("FAIL midframe_pixel5: got ready=%b (%0d,%0d) required 1 (0,1)", a_ready, a_posx, a_posy);
    end
    rst = 1;
    #1;
    tests_run++;
    if ({a_posx, a_posy, a_busy, a_done, a_err, a_ready} !== 28'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got posx=%0d posy=%0d busy=%b done=%b err=%b ready=%b required all 0",
               a_posx, a_posy, a_busy, a_done, a_err, a_ready);
    end
    tick();
    rst = 0;
    tick();
    a_log.delete(); a_done_cyc = -1;
    a_start = 1;
    tick();
    a_start = 0;
    for (int i = 0; i < 40 && a_done_cyc < 0; i++) tick();
    bad = 0;
    for (int i = 0; i < a_log.size() && i < 8; i++) begin
      if (a_log[i].x != i % 4 || a_log[i].y != i / 4) bad++;
    end
    tests_run++;
    if (a_done_cyc < 0 || a_log.size() != 8 || bad != 0 || a_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_frame: got done_cyc=%0d pixels=%0d bad=%0d err=%b required DONE 8 0 0",
               a_done_cyc, a_log.size(), bad, a_err);
    end
    $display("[TB] restart after reset done %0d", a_done_cyc);
  endtask

  task automatic test_wren_idle();
    int s;
    c_in_valid = 1;
    c_wren_inj = 1;
    tick();
    c_wren_inj = 0;
    tests_run++;
    if (c_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL wren_idle_err: got ERR=%b required 1", c_err);
    end
    c_log.delete(); c_done_cyc = -1;
    c_start = 1; s = cyc;
    tick();
    c_start = 0;
    tests_run++;
    if (c_err !== 1'b0 || c_ready !== 1'b1 || c_posx !== 12'd0 || c_posy !== 12'd0) begin
      tests_failed++;
      $display("FAIL one_by_one_issue: got err=%b ready=%b (%0d,%0d) required 0 1 (0,0)",
               c_err, c_ready, c_posx, c_posy);
    end
    for (int i = 0; i < 20 && c_done_cyc < 0; i++) tick();
    tests_run++;
    if (c_done_cyc != s + 4 || c_log.size() != 1) begin
      tests_failed++;
      $display("FAIL one_by_one_done: got DONE at %0d with %0d READY required %0d with 1",
               c_done_cyc, c_log.size(), s + 4);
    end
    tests_run++;
    if (c_err !== 1'b0 || c_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL one_by_one_end: got err=%b busy=%b required 0 0", c_err, c_busy);
    end
    $display("[TB] 1x1 frame started %0d done %0d", s, c_done_cyc);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_in_valid();
    test_credit_limit();
    test_credit_same_cycle();
    test_reset_midframe();
    test_wren_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
